// File: rtl/count_disp_driver.sv
`default_nettype none
// ============================================================================
//  Module   : count_disp_driver
//  Purpose  : Display driver that follows a 4-bit up/down counter. It
//             registers the count, decodes it to two multiplexed 7-segment
//             digits (decimal 00-15), shows the count direction on the
//             decimal point and stretches 15<->0 wrap events onto an LED.
//  Ports    : clk      - system clock, all logic on posedge
//             rst      - synchronous reset, active-high
//             q_in     - counter value (4 bits)
//             dir      - counter direction, 0 = up, 1 = down
//             seg      - segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//             dp       - decimal point, polarity per SEG_ACTIVE_LOW
//             an       - digit enables, active-low; an[0] ones, an[1] tens
//             wrap_led - high while a wrap event is being displayed
//  Config   : define COUNT_DISP_HEX_EN to show q as a single hex digit 0-F
//             on the ones position, with the tens digit always blank.
//  Revision : 1.0 - initial release
// ============================================================================
module count_disp_driver #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned WRAP_HOLD      = 25000000,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] q_in,
  input  logic       dir,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       wrap_led
);

  localparam int unsigned c_REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned c_HOLD_W    = $clog2(WRAP_HOLD + 1);

  localparam logic [c_REFRESH_W-1:0] c_REFRESH_LAST = c_REFRESH_W'(REFRESH_DIV - 1);
  localparam logic [c_HOLD_W-1:0]    c_HOLD_LOAD    = c_HOLD_W'(WRAP_HOLD);

  // Segment patterns are built active-low internally; c_INV flips seg/dp
  // for active-high boards. Digit enables are never inverted.
  localparam logic [6:0] c_BLANK = 7'b1111111;
  localparam logic       c_INV   = (SEG_ACTIVE_LOW == 0);

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] seg_code(input logic [3:0] v);
    logic [6:0] s;
    s = c_BLANK;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = c_BLANK;
    endcase
    return s;
  endfunction

  // Sample stage and wrap-detect history
  logic [3:0] r_q;
  logic       r_dir;
  logic       r_q_vld;    // r_q holds a real sample (not the reset value)
  logic [3:0] r_prev_q;
  logic       r_prev_vld; // r_prev_q holds a real sample

  // Scan and wrap-stretch state
  logic [c_REFRESH_W-1:0] r_refresh_cnt;
  logic                   r_digit_sel;
  logic [c_HOLD_W-1:0]    r_hold_cnt;

  // Registered outputs
  logic [6:0] r_seg;
  logic       r_dp;
  logic [1:0] r_an;
  logic       r_wrap_led;

  // Digit decode
  logic [3:0] w_ones_val;
  logic [6:0] w_tens_code;
  logic [6:0] w_ones_code;
  logic       w_wrap;

`ifdef COUNT_DISP_HEX_EN
  assign w_ones_val  = r_q;
  assign w_tens_code = c_BLANK;
`else
  logic w_tens;
  assign w_tens      = (r_q >= 4'd10);
  assign w_ones_val  = w_tens ? (r_q - 4'd10) : r_q;
  // Leading-zero blanking: the tens digit only ever shows a '1'.
  assign w_tens_code = w_tens ? seg_code(4'd1) : c_BLANK;
`endif

  assign w_ones_code = seg_code(w_ones_val);

  assign w_wrap = r_prev_vld &
                  (((r_prev_q == 4'hF) && (r_q == 4'h0)) ||
                   ((r_prev_q == 4'h0) && (r_q == 4'hF)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q           <= 4'd0;
      r_dir         <= 1'b0;
      r_q_vld       <= 1'b0;
      r_prev_q      <= 4'd0;
      r_prev_vld    <= 1'b0;
      r_refresh_cnt <= '0;
      r_digit_sel   <= 1'b0;
      r_hold_cnt    <= '0;
      r_an          <= 2'b11;
      r_seg         <= c_BLANK ^ {7{c_INV}};
      r_dp          <= 1'b1 ^ c_INV;
      r_wrap_led    <= 1'b0;
    end else begin
      r_q      <= q_in;
      r_dir    <= dir;
      r_q_vld  <= 1'b1;
      r_prev_q <= r_q;
      // Validity follows the sample one stage later, so the reset value of
      // r_q is never compared against the first real count.
      r_prev_vld <= r_q_vld;

      if (r_refresh_cnt == c_REFRESH_LAST) begin
        r_refresh_cnt <= '0;
        r_digit_sel   <= ~r_digit_sel;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end

      if (r_digit_sel == 1'b0) begin
        r_an  <= 2'b10;
        r_seg <= w_ones_code ^ {7{c_INV}};
        r_dp  <= ~r_dir ^ c_INV;
      end else begin
        r_an  <= 2'b01;
        r_seg <= w_tens_code ^ {7{c_INV}};
        r_dp  <= 1'b1 ^ c_INV;
      end

      // The LED tracks the next value of r_hold_cnt so it rises together
      // with the reload and stays high for exactly WRAP_HOLD cycles.
      if (w_wrap) begin
        r_hold_cnt <= c_HOLD_LOAD;
        r_wrap_led <= 1'b1;
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
        r_wrap_led <= (r_hold_cnt != c_HOLD_W'(1));
      end else begin
        r_wrap_led <= 1'b0;
      end
    end
  end

  assign seg      = r_seg;
  assign dp       = r_dp;
  assign an       = r_an;
  assign wrap_led = r_wrap_led;

endmodule
`default_nettype wire
